if_id_pipe_reg: RTL and testbench

Parametrised IF/ID pipeline register for the MIPS-style core. It replaces the bare instruction latch with a valid bit, stall hold, flush-to-bubble, and a one-entry skid buffer so fetch can run one cycle past a stall without losing an instruction. It sits between the fetch stage (PC plus instruction memory) and decode (register file, hazard unit, sign extend). Instruction fields are decoded from the registered instruction.

---
 rtl/if_id_pipe_reg.sv | 110 +++++++++++
 tb/tb_if_id_pipe_reg.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: valid bit, stall hold, flush-to-bubble and a one-entry skid buffer.
// Define IFID_PERF_EN to add saturating stall/flush event counters.
module if_id_pipe_reg #(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic [31:0]       inst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [31:0]       inst_o,
  output logic [5:0]        op_o,
  output logic [4:0]        rs_o,
  output logic [4:0]        rt_o,
  output logic [4:0]        rd_o,
  output logic [5:0]        funct_o,
  output logic [15:0]       imm16_o,
  output logic [25:0]       jaddr_o
`ifdef IFID_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  logic              m_valid;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_inst;
  logic              s_valid;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_inst;
  logic              accept;

  // Ready depends only on registered state, so stall/flush never reach fetch combinationally.
  assign ready_o = ~s_valid;
  assign accept  = valid_i & ready_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_valid <= 1'b0;
      m_addr  <= '0;
      m_inst  <= NOP_INST;
      s_valid <= 1'b0;
      s_addr  <= '0;
      s_inst  <= NOP_INST;
    end else if (flush_i) begin
      m_valid <= 1'b0;
      m_inst  <= NOP_INST;
      s_valid <= 1'b0;
      s_inst  <= NOP_INST;
    end else if (stall_i) begin
      if (accept) begin
        s_valid <= 1'b1;
        s_addr  <= inst_addr_i;
        s_inst  <= inst_i;
      end
    end else if (s_valid) begin
      // Skid entry drains first; fetch is blocked this cycle since ready_o is low.
      m_valid <= 1'b1;
      m_addr  <= s_addr;
      m_inst  <= s_inst;
      s_valid <= 1'b0;
      s_inst  <= NOP_INST;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_addr  <= inst_addr_i;
      m_inst  <= inst_i;
    end else begin
      m_valid <= 1'b0;
      m_inst  <= NOP_INST;
    end
  end

  assign valid_o     = m_valid;
  assign inst_addr_o = m_addr;
  assign inst_o      = m_inst;
  assign op_o        = m_inst[31:26];
  assign rs_o        = m_inst[25:21];
  assign rt_o        = m_inst[20:16];
  assign rd_o        = m_inst[15:11];
  assign funct_o     = m_inst[5:0];
  assign imm16_o     = m_inst[15:0];
  assign jaddr_o     = m_inst[25:0];

`ifdef IFID_PERF_EN
  logic stall_evt;
  logic flush_evt;

  assign stall_evt = stall_i & ~flush_i & m_valid;
  assign flush_evt = flush_i & (m_valid | s_valid);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_evt && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush_evt && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed self-checking bench for if_id_pipe_reg; covers perf counters when IFID_PERF_EN is defined.
module tb_if_id_pipe_reg;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_i;
  logic        valid_i;
  logic        ready_o;
  logic        stall_i;
  logic        flush_i;
  logic        valid_o;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_o;
  logic [5:0]  op_o;
  logic [4:0]  rs_o;
  logic [4:0]  rt_o;
  logic [4:0]  rd_o;
  logic [5:0]  funct_o;
  logic [15:0] imm16_o;
  logic [25:0] jaddr_o;
`ifdef IFID_PERF_EN
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;
  logic [1:0]  sat_stall_cnt;
  logic [1:0]  sat_flush_cnt;
  logic        sat_ready, sat_valid;
  logic [31:0] sat_addr, sat_inst;
  logic [5:0]  sat_op, sat_funct;
  logic [4:0]  sat_rs, sat_rt, sat_rd;
  logic [15:0] sat_imm;
  logic [25:0] sat_jaddr;
`endif

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  localparam logic [31:0] I_LW = 32'h8C22_0004;
  localparam logic [31:0] I_A  = 32'h0043_2020;
  localparam logic [31:0] I_B  = 32'h2021_0005;
  localparam logic [31:0] I_C  = 32'h012A_4020;

  always #5 clk_i = ~clk_i;

  if_id_pipe_reg #(
    .ADDR_W  (32),
    .NOP_INST(32'h0000_0000),
    .CNT_W   (16)
  ) u_dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .inst_addr_i(inst_addr_i),
    .inst_i     (inst_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .valid_o    (valid_o),
    .inst_addr_o(inst_addr_o),
    .inst_o     (inst_o),
    .op_o       (op_o),
    .rs_o       (rs_o),
    .rt_o       (rt_o),
    .rd_o       (rd_o),
    .funct_o    (funct_o),
    .imm16_o    (imm16_o),
    .jaddr_o    (jaddr_o)
`ifdef IFID_PERF_EN
    ,
    .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o)
`endif
  );

`ifdef IFID_PERF_EN
  if_id_pipe_reg #(
    .ADDR_W  (32),
    .NOP_INST(32'h0000_0000),
    .CNT_W   (2)
  ) u_sat (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .inst_addr_i(inst_addr_i),
    .inst_i     (inst_i),
    .valid_i    (valid_i),
    .ready_o    (sat_ready),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .valid_o    (sat_valid),
    .inst_addr_o(sat_addr),
    .inst_o     (sat_inst),
    .op_o       (sat_op),
    .rs_o       (sat_rs),
    .rt_o       (sat_rt),
    .rd_o       (sat_rd),
    .funct_o    (sat_funct),
    .imm16_o    (sat_imm),
    .jaddr_o    (sat_jaddr),
    .stall_cnt_o(sat_stall_cnt),
    .flush_cnt_o(sat_flush_cnt)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance one rising edge; outputs are sampled 1ns later, inputs changed there too.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] i,
                       input logic st, input logic fl);
    valid_i = v; inst_addr_i = a; inst_i = i; stall_i = st; flush_i = fl;
  endtask

  initial begin
    rst_n_i = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #12;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_inst",  inst_o, 32'h0);
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_op",    {26'd0, op_o}, 32'd0);
    chk("rst_addr",  inst_addr_o, 32'd0);
    rst_n_i = 1'b1;

    // Single lw streams through with one-cycle latency
    drive(1'b1, 32'h4, I_LW, 1'b0, 1'b0);
    cyc();
    chk("lw_valid", {31'd0, valid_o}, 32'd1);
    chk("lw_op",    {26'd0, op_o}, 32'h23);
    chk("lw_rs",    {27'd0, rs_o}, 32'd1);
    chk("lw_rt",    {27'd0, rt_o}, 32'd2);
    chk("lw_imm",   {16'd0, imm16_o}, 32'h4);
    chk("lw_addr",  inst_addr_o, 32'h4);
    chk("lw_jaddr", {6'd0, jaddr_o}, 32'h0022_0004);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    cyc();
    chk("bubble_valid", {31'd0, valid_o}, 32'd0);
    chk("bubble_inst",  inst_o, 32'h0);

    // Stall with skid: A held in M, B captured into S, C waits
    drive(1'b1, 32'h8, I_A, 1'b0, 1'b0);
    cyc();
    chk("a_inst",  inst_o, I_A);
    chk("a_funct", {26'd0, funct_o}, 32'h20);
    chk("a_rd",    {27'd0, rd_o}, 32'd4);
    drive(1'b1, 32'hC, I_B, 1'b1, 1'b0);
    cyc();
    chk("stall1_inst",  inst_o, I_A);
    chk("stall1_ready", {31'd0, ready_o}, 32'd0);
    drive(1'b1, 32'h10, I_C, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("stallN_inst",  inst_o, I_A);
      chk("stallN_ready", {31'd0, ready_o}, 32'd0);
    end
    stall_i = 1'b0;
    cyc();
    chk("rel_inst",  inst_o, I_B);
    chk("rel_addr",  inst_addr_o, 32'hC);
    chk("rel_ready", {31'd0, ready_o}, 32'd1);
    cyc();
    chk("c_inst",  inst_o, I_C);
    chk("c_addr",  inst_addr_o, 32'h10);
    chk("c_valid", {31'd0, valid_o}, 32'd1);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    cyc();

    // Flush with skid full drops C as well
    drive(1'b1, 32'h8, I_A, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'hC, I_B, 1'b1, 1'b0);
    cyc();
    chk("fl_pre_ready", {31'd0, ready_o}, 32'd0);
    drive(1'b1, 32'h10, I_C, 1'b0, 1'b1);
    cyc();
    chk("fl_valid", {31'd0, valid_o}, 32'd0);
    chk("fl_inst",  inst_o, 32'h0);
    chk("fl_ready", {31'd0, ready_o}, 32'd1);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    cyc();
    chk("fl_c_dropped", {31'd0, valid_o}, 32'd0);
    chk("fl_c_inst",    inst_o, 32'h0);

    // Flush beats stall
    drive(1'b1, 32'h8, I_A, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'h10, I_C, 1'b1, 1'b1);
    cyc();
    chk("flst_valid", {31'd0, valid_o}, 32'd0);
    chk("flst_inst",  inst_o, 32'h0);
    chk("flst_ready", {31'd0, ready_o}, 32'd1);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    cyc();
    chk("flst_after", {31'd0, valid_o}, 32'd0);

    // Async reset between edges with S full
    drive(1'b1, 32'h8, I_A, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'hC, I_B, 1'b1, 1'b0);
    cyc();
    chk("ar_pre_ready", {31'd0, ready_o}, 32'd0);
    #2 rst_n_i = 1'b0;
    #1;
    chk("ar_valid", {31'd0, valid_o}, 32'd0);
    chk("ar_ready", {31'd0, ready_o}, 32'd1);
    chk("ar_inst",  inst_o, 32'h0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1 rst_n_i = 1'b1;
    cyc();
    chk("ar_post_ready", {31'd0, ready_o}, 32'd1);
    chk("ar_post_valid", {31'd0, valid_o}, 32'd0);

`ifdef IFID_PERF_EN
    chk("pc_rst_stall", {16'd0, stall_cnt_o}, 32'd0);
    drive(1'b1, 32'h8, I_A, 1'b0, 1'b0);
    cyc();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    cyc();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h8, I_A, 1'b0, 1'b0);
      cyc();
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      cyc();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    cyc();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    cyc();
    chk("pc_stall", {16'd0, stall_cnt_o}, 32'd5);
    chk("pc_flush", {16'd0, flush_cnt_o}, 32'd2);
    chk("pc_sat_stall", {30'd0, sat_stall_cnt}, 32'd3);
    chk("pc_sat_flush", {30'd0, sat_flush_cnt}, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
